mul_div_unit: RTL and testbench

- Iterative signed 16-bit multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the forwarded operands and multiDiv function bits latched in ID/EX.
- Produces a low result word, which feeds the EX/M ALU-result field, and a high word (product high half or remainder), which feeds the EX/M R0 field.
- Holds the front of the pipeline via a stall output while iterating.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_unit_datapath.sv | 68 ++++++
 rtl/mul_div_unit.sv | 137 +++++++++++++
 tb/tb_mul_div_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: function
// encodings decoded from multiDiv[3:2], the FSM state encoding and the
// machine word width.
package cpu_defs;

  localparam int WORD_W = 16;

  localparam logic [1:0] MD_OP_NONE = 2'b00;
  localparam logic [1:0] MD_OP_MUL  = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_datapath.sv
// Combinational arithmetic for mul_div_unit: one shift-add multiply step
// or one restoring-divide step on the magnitude registers, plus the sign
// fix-up applied after the last iteration.
module md_datapath
  import cpu_defs::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             is_div,
  input  logic             neg_q,    // product / quotient must be negated
  input  logic             neg_r,    // remainder must be negated
  input  logic [WIDTH-1:0] acc_hi,   // product high half / partial remainder
  input  logic [WIDTH-1:0] acc_lo,   // multiplier bits / dividend-quotient
  input  logic [WIDTH-1:0] opb,      // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] step_hi,
  output logic [WIDTH-1:0] step_lo,
  output logic [WIDTH-1:0] fix_lo,
  output logic [WIDTH-1:0] fix_hi
);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted_rem;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   prod;

  // One iteration: multiply adds then shifts right, divide shifts left
  // then keeps the trial difference when it did not go negative.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    step_hi     = acc_hi;
    step_lo     = acc_lo;
    sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    // The partial remainder is below the divisor, so the shifted value
    // needs only the 17th bit as headroom for the trial subtraction.
    shifted_rem = {acc_hi, acc_lo[WIDTH-1]};
    trial       = shifted_rem - {1'b0, opb};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted_rem[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up: the product and quotient follow sign_a^sign_b, the
  // remainder follows the dividend.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_lo = acc_lo;
    fix_hi = acc_hi;
    if (neg_q) prod = -prod;
    if (is_div) begin
      if (neg_q) fix_lo = -acc_lo;
      if (neg_r) fix_hi = -acc_hi;
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit for the EX stage. Runs one
// iteration per cycle on operand magnitudes, applies signs in FIX and
// pulses done for one cycle while stall drops so EX/M captures results.
module mul_div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int              CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  md_state_e        state, state_next;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [CNT_W-1:0] count;
  logic             sign_a, sign_b, is_div;
  logic             op_valid, is_dz;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo, fix_lo, fix_hi;

  assign op_valid = start && (op == MD_OP_MUL || op == MD_OP_DIV);
  assign is_dz    = (op == MD_OP_DIV) && (b == '0);
  // |0x8000| wraps back to 0x8000, which is the correct unsigned magnitude.
  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign busy     = (state != MD_IDLE);

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .is_div  (is_div),
    .neg_q   (sign_a ^ sign_b),
    .neg_r   (sign_a),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .opb     (opb),
    .step_hi (step_hi),
    .step_lo (step_lo),
    .fix_lo  (fix_lo),
    .fix_hi  (fix_hi)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_next;
  end

  // Next-state, stall and done decode; flush overrides everything past IDLE.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      MD_IDLE: if (op_valid) begin
        stall      = 1'b1;
        state_next = is_dz ? MD_DONE : MD_RUN;
      end
      MD_RUN: begin
        stall = 1'b1;
        if (flush)              state_next = MD_IDLE;
        else if (count == LAST) state_next = MD_FIX;
      end
      MD_FIX: begin
        stall      = 1'b1;
        state_next = flush ? MD_IDLE : MD_DONE;
      end
      MD_DONE: begin
        done       = !flush;
        state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every datapath register has a reset value; there is no memory
    // here, so nothing is left to power up as X.
    if (!reset_n) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      count       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      is_div      <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (op_valid) begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          opb    <= b_mag;
          sign_a <= a[WIDTH-1];
          sign_b <= b[WIDTH-1];
          is_div <= (op == MD_OP_DIV);
          count  <= '0;
          if (is_dz) begin
            result_lo   <= '1;
            result_hi   <= a;
            div_by_zero <= 1'b1;
          end
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CNT_W'(1);
        end
        MD_FIX: if (!flush) begin
          result_lo   <= fix_lo;
          result_hi   <= fix_hi;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, random mul/div
// against an integer-arithmetic reference, flush and async-reset checks.
module tb_mul_div_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset_n, start, flush;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        stall, busy, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_lo = '0;
  logic [15:0] exp_hi = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(16), .ITER(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: plain signed integer arithmetic with C-style truncation.
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic dz, output int lat);
    int     sx, sy, q, r;
    longint p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == MD_OP_MUL) begin
      p  = longint'(sx) * longint'(sy);
      lo = p[15:0];
      hi = p[31:16];
      dz = 1'b0;
      lat = 18;
    end else if (sy == 0) begin
      lo = 16'hFFFF;
      hi = x;
      dz = 1'b1;
      lat = 1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      lo = q[15:0];
      hi = r[15:0];
      dz = 1'b0;
      lat = 18;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_lo"},    result_lo, 0);
    check({tag, "_hi"},    result_hi, 0);
    check({tag, "_dz"},    div_by_zero, 0);
  endtask

  // Issue one operation and follow it to its done pulse. With hold set,
  // start stays high through RUN with fresh random operands.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit hold);
    logic [15:0] elo, ehi;
    logic        edz;
    int          elat, cyc, stalls;
    bit          got;
    model(o, x, y, elo, ehi, edz, elat);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    check("stall_issue", stall, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      a = 16'($urandom);
      b = 16'($urandom);
    end else begin
      start = 1'b0;
    end
    #1;
    cyc = 1; stalls = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      if (done) got = 1'b1;
      else begin
        if (stall) stalls++;
        tick();
        cyc++;
      end
    end
    check("done_seen", got, 1);
    check("latency", cyc, elat);
    check("stall_cycles", stalls, elat - 1);
    if (got) begin
      check("stall_in_done", stall, 0);
      check("busy_in_done", busy, 1);
      check("result_lo", result_lo, elo);
      check("result_hi", result_hi, ehi);
      check("div_by_zero", div_by_zero, edz);
    end
    exp_lo = elo;
    exp_hi = ehi;
    start = 1'b0;
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    bit          seen;

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Directed cases and boundaries.
    do_op(MD_OP_MUL, 16'h0007, 16'hFFFD, 1'b0);
    do_op(MD_OP_DIV, 16'hFF9C, 16'h0007, 1'b0);
    do_op(MD_OP_DIV, 16'h0005, 16'h0000, 1'b0);
    do_op(MD_OP_DIV, 16'h8000, 16'hFFFF, 1'b0);
    do_op(MD_OP_MUL, 16'h8000, 16'h8000, 1'b0);

    // start held high through the operation with changing operands.
    do_op(MD_OP_MUL, 16'h1234, 16'hFF00, 1'b1);
    do_op(MD_OP_DIV, 16'h7FFF, 16'h0003, 1'b1);

    // op none and reserved are ignored.
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? MD_OP_NONE : MD_OP_RSVD;
      a = 16'h0011; b = 16'h0022; start = 1'b1;
      #1;
      check("nop_stall", stall, 0);
      tick(); tick();
      check("nop_busy", busy, 0);
      check("nop_done", done, 0);
      start = 1'b0;
    end
    tick();

    // Flush in RUN cycle 5: back to IDLE, no done, results untouched.
    op = MD_OP_MUL; a = 16'h1234; b = 16'h0011; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("flush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    check("flush_stall", stall, 0);
    check("flush_done", done, 0);
    check("flush_keep_lo", result_lo, exp_lo);
    check("flush_keep_hi", result_hi, exp_hi);
    seen = 1'b0;
    repeat (25) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("flush_no_done", seen, 0);

    // Random multiply/divide against the reference.
    for (int i = 0; i < 24; i++) begin
      ro = ($urandom_range(0, 1) == 1) ? MD_OP_MUL : MD_OP_DIV;
      rx = 16'($urandom);
      ry = (i % 8 == 7) ? 16'h0000 : 16'($urandom);
      do_op(ro, rx, ry, 1'b0);
    end

    // Asynchronous reset between edges in the middle of RUN.
    op = MD_OP_MUL; a = 16'h4321; b = 16'h0077; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #2;
    reset_n = 1'b1;
    tick();
    check("post_reset_done", done, 0);
    do_op(MD_OP_MUL, 16'h0003, 16'h0004, 1'b0);
    check("mul3x4_lo", result_lo, 16'h000C);
    check("mul3x4_hi", result_hi, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
